// File: rtl/fake_netlist_seq_pkg.sv
// Shared types and constants for the fake-netlist stimulus sequencer and its LFSR.
// No latency or backpressure of its own; purely declarations.
package fake_netlist_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] MISR_POLY    = 16'h1021;
    localparam logic [15:0] DEFAULT_SEED = 16'h0001;

    // Fibonacci step, taps 16,14,13,11, shifting left with feedback into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fake_netlist_lfsr16.sv
// 16-bit pattern LFSR with synchronous load and step enable; new value visible one cycle after load/en.
// No backpressure: load has priority over enable, otherwise the state holds.
module fake_netlist_lfsr16
    import fake_netlist_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_en,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= i_load_val;
        end else if (i_en) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/fake_netlist_stim_sequencer.sv
// Drives LFSR patterns into a fake netlist cone, waits SETTLE_CYC, compacts resp_i into a MISR; SETTLE_CYC+2 cycles per pattern.
// No backpressure: start_i ignored while busy, abort_i wins everywhere. FAKE_NETLIST_STIM_SEQ_GOLDEN_EN adds golden compare.
module fake_netlist_stim_sequencer
    import fake_netlist_seq_pkg::*;
#(
    parameter int N_IN       = 13,
    parameter int LFSR_W     = 16,
    parameter int SIG_W      = 16,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic [CNT_W-1:0]  num_pat_i,
    input  logic              resp_i,
`ifdef FAKE_NETLIST_STIM_SEQ_GOLDEN_EN
    input  logic [SIG_W-1:0]  golden_i,
    output logic              pass_o,
    output logic              fail_o,
`endif
    output logic [N_IN-1:0]   stim_o,
    output logic              stim_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [SIG_W-1:0]  sig_o,
    output logic [CNT_W-1:0]  pat_cnt_o
);

    localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    seq_state_e         r_state;
    seq_state_e         w_next;
    logic [CNT_W-1:0]   r_num_pat;
    logic [CNT_W-1:0]   r_pat_cnt;
    logic [CNT_W-1:0]   w_cnt_d;
    logic [SIG_W-1:0]   r_sig;
    logic [SIG_W-1:0]   w_sig_d;
    logic [SC_W-1:0]    r_settle;
    logic               r_busy;
    logic               r_valid;
    logic               r_done;
    logic               w_start;
    logic               w_lfsr_load;
    logic               w_lfsr_en;
    logic [LFSR_W-1:0]  w_seed;
    logic [LFSR_W-1:0]  w_lfsr_q;
    logic               w_unused;

    assign w_seed = (seed_i == '0) ? DEFAULT_SEED : seed_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_lfsr_en = 1'b0;
        w_sig_d   = r_sig;
        w_cnt_d   = r_pat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_start = 1'b1;
                    w_sig_d = '0;
                    w_cnt_d = '0;
                    w_next  = (num_pat_i == '0) ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DRIVE:  w_next = ST_SETTLE;
            ST_SETTLE: begin
                if (r_settle == SC_W'(SETTLE_CYC - 1)) begin
                    w_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_lfsr_en = 1'b1;
                w_sig_d   = (r_sig << 1) ^ (r_sig[SIG_W-1] ? SIG_W'(MISR_POLY) : '0) ^ SIG_W'(resp_i);
                w_cnt_d   = r_pat_cnt + CNT_W'(1);
                w_next    = (w_cnt_d == r_num_pat) ? ST_DONE : ST_DRIVE;
            end
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (abort_i) begin
            w_next    = ST_IDLE;
            w_start   = 1'b0;
            w_lfsr_en = 1'b0;
            w_sig_d   = r_sig;
            w_cnt_d   = r_pat_cnt;
        end
    end

    // LFSR only moves when a new DRIVE begins, so stim_o holds once a run ends.
    assign w_lfsr_load = w_start && (w_next == ST_DRIVE);

    fake_netlist_lfsr16 u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_lfsr_load),
        .i_load_val (w_seed),
        .i_en       (w_lfsr_en && (w_next == ST_DRIVE)),
        .o_state    (w_lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_pat <= '0;
            r_pat_cnt <= '0;
            r_sig     <= '0;
            r_settle  <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_start) begin
                r_num_pat <= num_pat_i;
            end
            r_pat_cnt <= w_cnt_d;
            r_sig     <= w_sig_d;
            r_settle  <= (r_state == ST_SETTLE) ? r_settle + SC_W'(1) : '0;
            r_busy    <= (w_next != ST_IDLE);
            r_valid   <= (w_next == ST_DRIVE) || (w_next == ST_SETTLE) || (w_next == ST_CAPTURE);
            r_done    <= (w_next == ST_DONE);
        end
    end

`ifdef FAKE_NETLIST_STIM_SEQ_GOLDEN_EN
    logic r_pass;
    logic r_fail;

    // Verdict is formed from the final signature on the edge entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (abort_i) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (w_next == ST_DONE) begin
            r_pass <= (w_sig_d == golden_i);
            r_fail <= (w_sig_d != golden_i);
        end else if (w_start) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end
    end

    assign pass_o = r_pass;
    assign fail_o = r_fail;
`endif

    assign w_unused     = ^(w_lfsr_q >> N_IN);
    assign stim_o       = w_lfsr_q[N_IN-1:0];
    assign stim_valid_o = r_valid;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign sig_o        = r_sig;
    assign pat_cnt_o    = r_pat_cnt;

endmodule

// File: tb/tb_fake_netlist_stim_sequencer.sv
// Directed table-driven bench for fake_netlist_stim_sequencer plus multi-cycle corner sequences.
module tb_fake_netlist_stim_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        abort_i;
    logic [15:0] seed_i;
    logic [15:0] num_pat_i;
    logic        resp_i;
    logic [12:0] stim_o;
    logic        stim_valid_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] sig_o;
    logic [15:0] pat_cnt_o;
`ifdef FAKE_NETLIST_STIM_SEQ_GOLDEN_EN
    logic [15:0] golden_i;
    logic        pass_o;
    logic        fail_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fake_netlist_stim_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .seed_i       (seed_i),
        .num_pat_i    (num_pat_i),
        .resp_i       (resp_i),
`ifdef FAKE_NETLIST_STIM_SEQ_GOLDEN_EN
        .golden_i     (golden_i),
        .pass_o       (pass_o),
        .fail_o       (fail_o),
`endif
        .stim_o       (stim_o),
        .stim_valid_o (stim_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .sig_o        (sig_o),
        .pat_cnt_o    (pat_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] seed;
        logic [15:0] n;
        logic        resp;
        logic [12:0] s1;
        logic [12:0] s2;
        logic [15:0] sig;
        logic [15:0] cnt;
        int          lat;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] seed, input logic [15:0] n, input logic resp);
        seed_i    = seed;
        num_pat_i = n;
        resp_i    = resp;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
    endtask

    // Starts a run and returns the start-to-done latency; stim checks along the way.
    task automatic run(input logic [15:0] seed, input logic [15:0] n, input logic resp,
                       input logic [12:0] s1, input logic [12:0] s2, output int lat);
        do_start(seed, n, resp);
        lat = 1;
        while (!done_o && lat < 200) begin
            if (lat <= 4 && n > 0) begin
                chk("stim_first", 32'(stim_o), 32'(s1));
                chk("stim_valid", 32'(stim_valid_o), 32'd1);
            end
            if (lat == 5 && n >= 2) chk("stim_second", 32'(stim_o), 32'(s2));
            tick();
            lat++;
        end
        if (!done_o) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int  lat;
        logic saw_done;

        vecs[0] = '{16'h0001, 16'd1,  1'b0, 13'h0001, 13'h0000, 16'h0000, 16'd1,  5};
        vecs[1] = '{16'h0001, 16'd2,  1'b1, 13'h0001, 13'h0002, 16'h0003, 16'd2,  9};
        vecs[2] = '{16'h0000, 16'd1,  1'b1, 13'h0001, 13'h0000, 16'h0001, 16'd1,  5};
        vecs[3] = '{16'h1234, 16'd0,  1'b1, 13'h0000, 13'h0000, 16'h0000, 16'd0,  1};
        vecs[4] = '{16'hFFFF, 16'd3,  1'b1, 13'h1FFF, 13'h1FFE, 16'h0007, 16'd3,  13};
        vecs[5] = '{16'hACE1, 16'd17, 1'b1, 13'h0CE1, 13'h19C3, 16'hEFDE, 16'd17, 69};

        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        seed_i = '0; num_pat_i = '0; resp_i = 1'b0;
`ifdef FAKE_NETLIST_STIM_SEQ_GOLDEN_EN
        golden_i = 16'h0003;
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_stim",  32'(stim_o), 32'd0);
        chk("rst_valid", 32'(stim_valid_o), 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_done",  32'(done_o), 32'd0);
        chk("rst_sig",   32'(sig_o), 32'd0);
        chk("rst_cnt",   32'(pat_cnt_o), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run(vecs[i].seed, vecs[i].n, vecs[i].resp, vecs[i].s1, vecs[i].s2, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_busy_at_done", i), 32'(busy_o), 32'd1);
            chk($sformatf("v%0d_sig", i), 32'(sig_o), 32'(vecs[i].sig));
            chk($sformatf("v%0d_cnt", i), 32'(pat_cnt_o), 32'(vecs[i].cnt));
            tick();
            chk($sformatf("v%0d_done_pulse", i), 32'(done_o), 32'd0);
            chk($sformatf("v%0d_busy_after", i), 32'(busy_o), 32'd0);
            chk($sformatf("v%0d_sig_hold", i), 32'(sig_o), 32'(vecs[i].sig));
            tick();
        end

        // Abort inside the third pattern of a 10-pattern run.
        do_start(16'h0001, 16'd10, 1'b1);
        repeat (9) tick();
        chk("abort_pre_valid", 32'(stim_valid_o), 32'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_busy",  32'(busy_o), 32'd0);
        chk("abort_valid", 32'(stim_valid_o), 32'd0);
        chk("abort_cnt",   32'(pat_cnt_o), 32'd2);
        chk("abort_sig",   32'(sig_o), 32'h3);
        saw_done = done_o;
        repeat (8) begin
            tick();
            saw_done = saw_done | done_o;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        run(16'h0001, 16'd1, 1'b0, 13'h0001, 13'h0000, lat);
        chk("abort_restart_lat", 32'(lat), 32'd5);
        chk("abort_restart_cnt", 32'(pat_cnt_o), 32'd1);
        repeat (2) tick();

        // start and abort together in IDLE: stays idle.
        seed_i = 16'h0001; num_pat_i = 16'd3; start_i = 1'b1; abort_i = 1'b1;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        chk("start_abort_busy", 32'(busy_o), 32'd0);
        tick();
        chk("start_abort_busy2", 32'(busy_o), 32'd0);

        // start while busy is ignored.
        do_start(16'h0001, 16'd2, 1'b1);
        tick();
        num_pat_i = 16'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        lat = 3;
        while (!done_o && lat < 200) begin
            tick();
            lat++;
        end
        chk("busy_start_lat", 32'(lat), 32'd9);
        chk("busy_start_cnt", 32'(pat_cnt_o), 32'd2);
        repeat (2) tick();

        // Asynchronous reset in SETTLE of the second pattern.
        do_start(16'h0001, 16'd5, 1'b1);
        repeat (5) tick();
        chk("midrst_pre_stim", 32'(stim_o), 32'h0002);
        chk("midrst_pre_cnt", 32'(pat_cnt_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_stim",  32'(stim_o), 32'd0);
        chk("midrst_valid", 32'(stim_valid_o), 32'd0);
        chk("midrst_busy",  32'(busy_o), 32'd0);
        chk("midrst_sig",   32'(sig_o), 32'd0);
        chk("midrst_cnt",   32'(pat_cnt_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run(16'h0001, 16'd1, 1'b0, 13'h0001, 13'h0000, lat);
        chk("midrst_after_lat", 32'(lat), 32'd5);
        chk("midrst_after_sig", 32'(sig_o), 32'd0);
        repeat (2) tick();

`ifdef FAKE_NETLIST_STIM_SEQ_GOLDEN_EN
        golden_i = 16'h0003;
        run(16'h0001, 16'd2, 1'b1, 13'h0001, 13'h0002, lat);
        chk("golden_pass", 32'(pass_o), 32'd1);
        chk("golden_pass_fail", 32'(fail_o), 32'd0);
        repeat (2) tick();
        chk("golden_pass_hold", 32'(pass_o), 32'd1);
        golden_i = 16'h0004;
        run(16'h0001, 16'd2, 1'b1, 13'h0001, 13'h0002, lat);
        chk("golden_fail", 32'(fail_o), 32'd1);
        chk("golden_fail_pass", 32'(pass_o), 32'd0);
        repeat (2) tick();
        do_start(16'h0001, 16'd4, 1'b1);
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("golden_abort_fail", 32'(fail_o), 32'd0);
        chk("golden_abort_pass", 32'(pass_o), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
